// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared types and sizing for the processor<->memory port arbiter:
//   - bus_command_t : command encoding on every request/memory port
//   - arb_state_t   : arbiter grant/lock state
//   - arb_owner_t   : which cache controller owns an outstanding memory tag
//   - ARB_NUM_TAGS / ARB_TAG_W / ARB_STARVE_LIMIT : default sizing
// -----------------------------------------------------------------------------
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package mem_bus_arbiter_pkg;

  // Valid memory tags are 1..ARB_NUM_TAGS; tag 0 means "no tag".
  localparam int ARB_NUM_TAGS     = `NUM_MEM_TAGS;
  localparam int ARB_TAG_W        = $clog2(ARB_NUM_TAGS + 1);
  localparam int ARB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef enum logic [1:0] {
    ARB_FREE   = 2'h0,
    ARB_LOCK_D = 2'h1,
    ARB_LOCK_I = 2'h2
  } arb_state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } arb_owner_t;

  typedef logic [ARB_TAG_W-1:0] tag_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles every bus signal around the arbiter:
//   d2arb_*     dcache controller request (command, addr, store data)
//   i2arb_*     icache controller request (command, addr)
//   mem2proc_*  memory accept tag, return tag and return data
//   proc2mem_*  request issued to memory
//   arb2d_* / arb2i_*  per-requester accept tag, return tag, return data
//   orphan_tag  pulse for a returned tag with no recorded owner
// Modports:
//   master : the arbiter's view (drives proc2mem_*, arb2*_*, orphan_tag)
//   slave  : the surrounding caches/memory view (drives requests and memory)
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  bus_command_t d2arb_command;
  logic [31:0]  d2arb_addr;
  logic [63:0]  d2arb_data;

  bus_command_t i2arb_command;
  logic [31:0]  i2arb_addr;

  tag_t         mem2proc_response;
  logic [63:0]  mem2proc_data;
  tag_t         mem2proc_tag;

  bus_command_t proc2mem_command;
  logic [31:0]  proc2mem_addr;
  logic [63:0]  proc2mem_data;

  tag_t         arb2d_response;
  tag_t         arb2i_response;
  tag_t         arb2d_tag;
  tag_t         arb2i_tag;
  logic [63:0]  arb2d_data;
  logic [63:0]  arb2i_data;
  logic         orphan_tag;

  modport master (
    input  d2arb_command, d2arb_addr, d2arb_data,
    input  i2arb_command, i2arb_addr,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output arb2d_response, arb2i_response,
    output arb2d_tag, arb2i_tag, arb2d_data, arb2i_data,
    output orphan_tag
  );

  modport slave (
    output d2arb_command, d2arb_addr, d2arb_data,
    output i2arb_command, i2arb_addr,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  arb2d_response, arb2i_response,
    input  arb2d_tag, arb2i_tag, arb2d_data, arb2i_data,
    input  orphan_tag
  );

endinterface

// File: rtl/mem_tag_owner_table.sv
// -----------------------------------------------------------------------------
// mem_tag_owner_table
// Remembers which requester owns each outstanding memory tag.
// Ports:
//   clock, reset            clock, asynchronous active-low reset (clears valids)
//   alloc_en/tag/owner      record alloc_owner as owner of alloc_tag
//   ret_tag                 tag currently returning from memory (0 = none)
//   ret_hit/ret_owner       ret_tag is outstanding, and who owns it
//   ret_orphan              ret_tag is nonzero but not outstanding
// A hit retires the entry at the clock edge. If the same tag is retired and
// allocated together, the lookup sees the old owner and the allocate wins.
// -----------------------------------------------------------------------------
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = ARB_NUM_TAGS,
  parameter int TAG_W    = ARB_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  arb_owner_t       alloc_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic             ret_hit,
  output arb_owner_t       ret_owner,
  output logic             ret_orphan
);

  logic [NUM_TAGS:1] valid_q, valid_d;
  arb_owner_t        owner_q [1:NUM_TAGS];
  arb_owner_t        owner_d [1:NUM_TAGS];

  // Lookup of the returning tag against the current table contents.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    ret_hit   = 1'b0;
    ret_owner = OWN_D;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      if (ret_tag == TAG_W'(i) && valid_q[i]) begin
        ret_hit   = 1'b1;
        ret_owner = owner_q[i];
      end
    end
    ret_orphan = (ret_tag != '0) && !ret_hit;
  end

  // Retire first, then allocate, so an allocate of the same tag takes effect.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      if (ret_hit && ret_tag == TAG_W'(i)) begin
        valid_d[i] = 1'b0;
      end
      if (alloc_en && alloc_tag == TAG_W'(i)) begin
        valid_d[i] = 1'b1;
        owner_d[i] = alloc_owner;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: the owner bits are storage qualified by valid_q, so they carry no
  // reset; only the valid bits need a known value after reset.
  always_ff @(posedge clock) begin
    owner_q <= owner_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the single processor<->memory port between the dcache controller
// (loads and stores) and the icache controller (loads only).
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset; all outputs forced to 0/BUS_NONE
//   bus    mem_bus_arbiter_if.master carrying all request/memory signals
// The granted request reaches memory in the same cycle. A grant that memory
// does not accept (response 0) is locked until accepted or withdrawn. icache
// wins a free arbitration once it has been denied STARVE_LIMIT cycles.
// Accepted loads record their tag owner; returning data goes to that owner.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic               clock,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic         d_req, i_req;
  logic         grant_d, grant_i;
  logic         accepted;
  logic         alloc_en;
  bus_command_t grant_cmd;
  arb_owner_t   alloc_owner;
  logic         ret_hit;
  arb_owner_t   ret_owner;
  logic         ret_orphan;

  // Grant selection.
  always_comb begin
    d_req   = (bus.d2arb_command != BUS_NONE);
    i_req   = (bus.i2arb_command != BUS_NONE);
    grant_d = 1'b0;
    grant_i = 1'b0;
    unique case (state_q)
      ARB_FREE: begin
        grant_i = i_req && (!d_req || starve_q >= STARVE_MAX);
        grant_d = d_req && !grant_i;
      end
      // A locked requester keeps the port; withdrawing its command frees it.
      ARB_LOCK_D: grant_d = d_req;
      ARB_LOCK_I: grant_i = i_req;
      default: ;
    endcase
    grant_cmd   = grant_d ? bus.d2arb_command :
                  grant_i ? bus.i2arb_command : BUS_NONE;
    accepted    = (grant_d || grant_i) && (bus.mem2proc_response != '0);
    alloc_en    = accepted && (grant_cmd == BUS_LOAD);
    alloc_owner = grant_i ? OWN_I : OWN_D;
  end

  // Next state and starvation count.
  always_comb begin
    state_d = ARB_FREE;
    if (grant_d && !accepted) begin
      state_d = ARB_LOCK_D;
    end else if (grant_i && !accepted) begin
      state_d = ARB_LOCK_I;
    end

    starve_d = starve_q;
    if (grant_i && accepted) begin
      starve_d = '0;
    end else if (i_req && !grant_i && starve_q < STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state_q  <= ARB_FREE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  mem_tag_owner_table #(
    .NUM_TAGS (ARB_NUM_TAGS),
    .TAG_W    (ARB_TAG_W)
  ) u_owner_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (bus.mem2proc_response),
    .alloc_owner (alloc_owner),
    .ret_tag     (bus.mem2proc_tag),
    .ret_hit     (ret_hit),
    .ret_owner   (ret_owner),
    .ret_orphan  (ret_orphan)
  );

  // Output steering. Outputs depend on inputs combinationally, so they are
  // gated by reset to stay quiet while requesters are still in reset.
  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.arb2d_response   = '0;
    bus.arb2i_response   = '0;
    bus.arb2d_tag        = '0;
    bus.arb2i_tag        = '0;
    bus.arb2d_data       = '0;
    bus.arb2i_data       = '0;
    bus.orphan_tag       = 1'b0;
    if (reset) begin
      if (grant_d) begin
        bus.proc2mem_command = bus.d2arb_command;
        bus.proc2mem_addr    = bus.d2arb_addr;
        bus.proc2mem_data    = bus.d2arb_data;
        bus.arb2d_response   = bus.mem2proc_response;
      end else if (grant_i) begin
        bus.proc2mem_command = bus.i2arb_command;
        bus.proc2mem_addr    = bus.i2arb_addr;
        bus.arb2i_response   = bus.mem2proc_response;
      end
      if (ret_hit) begin
        if (ret_owner == OWN_D) begin
          bus.arb2d_tag  = bus.mem2proc_tag;
          bus.arb2d_data = bus.mem2proc_data;
        end else begin
          bus.arb2i_tag  = bus.mem2proc_tag;
          bus.arb2i_data = bus.mem2proc_data;
        end
      end
      bus.orphan_tag = ret_orphan;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed table of {inputs, expected outputs} applied one per clock, plus
// hand-written sequences for starvation cadence, same-cycle retire/allocate
// and asynchronous reset in the middle of a locked request.
// Inputs change just after the falling edge; outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bus_command_t d_cmd;
    logic [31:0]  d_addr;
    logic [63:0]  d_data;
    bus_command_t i_cmd;
    logic [31:0]  i_addr;
    tag_t         resp;
    tag_t         mtag;
    logic [63:0]  mdata;
    bus_command_t e_cmd;
    logic [31:0]  e_addr;
    logic [63:0]  e_data;
    tag_t         e_dresp;
    tag_t         e_iresp;
    tag_t         e_dtag;
    tag_t         e_itag;
    logic [63:0]  e_ddata;
    logic [63:0]  e_idata;
    logic         e_orphan;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.d2arb_command     = v.d_cmd;
    bus.d2arb_addr        = v.d_addr;
    bus.d2arb_data        = v.d_data;
    bus.i2arb_command     = v.i_cmd;
    bus.i2arb_addr        = v.i_addr;
    bus.mem2proc_response = v.resp;
    bus.mem2proc_tag      = v.mtag;
    bus.mem2proc_data     = v.mdata;
  endtask

  task automatic compare(input vec_t v, input string tag);
    check({tag, ".proc2mem_command"}, 64'(bus.proc2mem_command), 64'(v.e_cmd));
    check({tag, ".proc2mem_addr"},    64'(bus.proc2mem_addr),    64'(v.e_addr));
    check({tag, ".proc2mem_data"},    bus.proc2mem_data,         v.e_data);
    check({tag, ".arb2d_response"},   64'(bus.arb2d_response),   64'(v.e_dresp));
    check({tag, ".arb2i_response"},   64'(bus.arb2i_response),   64'(v.e_iresp));
    check({tag, ".arb2d_tag"},        64'(bus.arb2d_tag),        64'(v.e_dtag));
    check({tag, ".arb2i_tag"},        64'(bus.arb2i_tag),        64'(v.e_itag));
    check({tag, ".arb2d_data"},       bus.arb2d_data,            v.e_ddata);
    check({tag, ".arb2i_data"},       bus.arb2i_data,            v.e_idata);
    check({tag, ".orphan_tag"},       64'(bus.orphan_tag),       64'(v.e_orphan));
  endtask

  // Drive, compare before the next rising edge, then move to the next cycle.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    compare(v, tag);
    @(negedge clock);
  endtask

  localparam vec_t IDLE = '{BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0,
                            BUS_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0};

  vec_t tbl [17];
  vec_t v;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           d_cmd      d_addr     d_data       i_cmd     i_addr     rsp mtag mdata
    //           e_cmd      e_addr     e_data       dresp iresp dtag itag ddata     idata   orph
    tbl[0]  = IDLE;
    // Lone dcache load accepted with tag 3.
    tbl[1]  = '{BUS_LOAD,  32'h100, 64'h11,   BUS_NONE, 32'h0,   3, 0, 64'h0,
                BUS_LOAD,  32'h100, 64'h11,   3, 0, 0, 0, 64'h0,    64'h0,    1'b0};
    // Tag 3 returns to dcache.
    tbl[2]  = '{BUS_NONE,  32'h0,   64'h0,    BUS_NONE, 32'h0,   0, 3, 64'hDEAD,
                BUS_NONE,  32'h0,   64'h0,    0, 0, 3, 0, 64'hDEAD, 64'h0,    1'b0};
    // Both request, memory busy 4 cycles: dcache granted then locked.
    tbl[3]  = '{BUS_LOAD,  32'h200, 64'h22,   BUS_LOAD, 32'h300, 0, 0, 64'h0,
                BUS_LOAD,  32'h200, 64'h22,   0, 0, 0, 0, 64'h0,    64'h0,    1'b0};
    tbl[4]  = tbl[3];
    tbl[5]  = tbl[3];
    tbl[6]  = tbl[3];
    // Starve count is at the limit, but the lock keeps dcache; accepted with 5.
    tbl[7]  = '{BUS_LOAD,  32'h200, 64'h22,   BUS_LOAD, 32'h300, 5, 0, 64'h0,
                BUS_LOAD,  32'h200, 64'h22,   5, 0, 0, 0, 64'h0,    64'h0,    1'b0};
    // Free again: starved icache wins, data forced to 0.
    tbl[8]  = '{BUS_LOAD,  32'h200, 64'h22,   BUS_LOAD, 32'h300, 6, 0, 64'h0,
                BUS_LOAD,  32'h300, 64'h0,    0, 6, 0, 0, 64'h0,    64'h0,    1'b0};
    tbl[9]  = '{BUS_NONE,  32'h0,   64'h0,    BUS_NONE, 32'h0,   0, 6, 64'hBEEF,
                BUS_NONE,  32'h0,   64'h0,    0, 0, 0, 6, 64'h0,    64'hBEEF, 1'b0};
    tbl[10] = '{BUS_NONE,  32'h0,   64'h0,    BUS_NONE, 32'h0,   0, 5, 64'h55,
                BUS_NONE,  32'h0,   64'h0,    0, 0, 5, 0, 64'h55,   64'h0,    1'b0};
    // Accepted store allocates nothing; its tag return is an orphan.
    tbl[11] = '{BUS_STORE, 32'h400, 64'hCAFE, BUS_NONE, 32'h0,   7, 0, 64'h0,
                BUS_STORE, 32'h400, 64'hCAFE, 7, 0, 0, 0, 64'h0,    64'h0,    1'b0};
    tbl[12] = '{BUS_NONE,  32'h0,   64'h0,    BUS_NONE, 32'h0,   0, 7, 64'h77,
                BUS_NONE,  32'h0,   64'h0,    0, 0, 0, 0, 64'h0,    64'h0,    1'b1};
    tbl[13] = IDLE;
    // dcache locks, then withdraws: no command that cycle even though icache waits.
    tbl[14] = '{BUS_LOAD,  32'h500, 64'h33,   BUS_NONE, 32'h0,   0, 0, 64'h0,
                BUS_LOAD,  32'h500, 64'h33,   0, 0, 0, 0, 64'h0,    64'h0,    1'b0};
    tbl[15] = '{BUS_NONE,  32'h0,   64'h0,    BUS_LOAD, 32'h600, 9, 0, 64'h0,
                BUS_NONE,  32'h0,   64'h0,    0, 0, 0, 0, 64'h0,    64'h0,    1'b0};
    tbl[16] = '{BUS_NONE,  32'h0,   64'h0,    BUS_LOAD, 32'h600, 9, 0, 64'h0,
                BUS_LOAD,  32'h600, 64'h0,    0, 9, 0, 0, 64'h0,    64'h0,    1'b0};

    // Reset held low with active inputs: everything quiet.
    v = '{BUS_LOAD, 32'h100, 64'h1, BUS_LOAD, 32'h200, 3, 3, 64'h1,
          BUS_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0};
    apply(v, "reset_hold");
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i], $sformatf("tbl[%0d]", i));
    end

    // Both request every cycle, memory always accepts: icache gets every 5th.
    for (int k = 0; k < 15; k++) begin
      v = '{BUS_LOAD, 32'hA00, 64'h44, BUS_LOAD, 32'hB00, 1, 0, 64'h0,
            BUS_LOAD, 32'hA00, 64'h44, 1, 0, 0, 0, 64'h0, 64'h0, 1'b0};
      if (k % 5 == 4) begin
        v.e_addr  = 32'hB00;
        v.e_data  = 64'h0;
        v.e_dresp = 0;
        v.e_iresp = 1;
      end
      apply(v, $sformatf("starve[%0d]", k));
    end

    // icache takes tag 4, then tag 4 returns while dcache is given tag 4.
    v = IDLE;
    v.i_cmd = BUS_LOAD; v.i_addr = 32'hC00; v.resp = 4;
    v.e_cmd = BUS_LOAD; v.e_addr = 32'hC00; v.e_iresp = 4;
    apply(v, "same_tag.alloc_i");
    v = IDLE;
    v.d_cmd = BUS_LOAD; v.d_addr = 32'hD00; v.d_data = 64'h66; v.resp = 4;
    v.mtag = 4; v.mdata = 64'h4444;
    v.e_cmd = BUS_LOAD; v.e_addr = 32'hD00; v.e_data = 64'h66; v.e_dresp = 4;
    v.e_itag = 4; v.e_idata = 64'h4444;
    apply(v, "same_tag.swap");
    v = IDLE;
    v.mtag = 4; v.mdata = 64'h8888; v.e_dtag = 4; v.e_ddata = 64'h8888;
    apply(v, "same_tag.ret_d");

    // Three loads outstanding (tags 1..3), then icache locks the port.
    v = IDLE;
    v.d_cmd = BUS_LOAD; v.d_addr = 32'hE00; v.resp = 1;
    v.e_cmd = BUS_LOAD; v.e_addr = 32'hE00; v.e_dresp = 1;
    apply(v, "rst_seq.t1");
    v.d_addr = 32'hE08; v.resp = 2; v.e_addr = 32'hE08; v.e_dresp = 2;
    apply(v, "rst_seq.t2");
    v = IDLE;
    v.i_cmd = BUS_LOAD; v.i_addr = 32'hF00; v.resp = 3;
    v.e_cmd = BUS_LOAD; v.e_addr = 32'hF00; v.e_iresp = 3;
    apply(v, "rst_seq.t3");
    v.i_addr = 32'h900; v.resp = 0; v.e_addr = 32'h900; v.e_iresp = 0;
    apply(v, "rst_seq.lock_i");
    // Still locked to icache although dcache now requests too.
    v.d_cmd = BUS_LOAD; v.d_addr = 32'hE10;
    drive(v);
    #1;
    compare(v, "rst_seq.held_i");
    // Reset mid-cycle with live inputs: outputs drop at once.
    #2;
    reset = 1'b0;
    v.resp = 5; v.mtag = 1; v.mdata = 64'h99;
    drive(v);
    #1;
    compare(IDLE, "rst_seq.async");
    @(negedge clock);
    drive(IDLE);
    @(negedge clock);
    reset = 1'b1;
    // Tags recorded before reset are gone.
    for (int t = 1; t <= 3; t++) begin
      v = IDLE;
      v.mtag = tag_t'(t); v.mdata = 64'h123; v.e_orphan = 1'b1;
      apply(v, $sformatf("rst_seq.orphan%0d", t));
    end
    apply(IDLE, "rst_seq.quiet");
    // Free state with cleared starve count: dcache wins a tie.
    v = IDLE;
    v.d_cmd = BUS_LOAD; v.d_addr = 32'h1000; v.i_cmd = BUS_LOAD; v.i_addr = 32'h2000;
    v.e_cmd = BUS_LOAD; v.e_addr = 32'h1000;
    apply(v, "rst_seq.free");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
